ram_rd_check: RTL and testbench
===============================

# ram_rd_check

Read-back checker for the on-board 256×8 test RAM. It sits on the RAM read port, opposite the write-side controller that fills each location with its own address. On a start pulse it sweeps addresses 0..255 at a programmable pace and compensates for the RAM read latency. It compares every returned byte against the expected pattern and reports pass/fail, the error count and the first failing address.

## Interface
- ADDR_W, 8: RAM address width; sweep covers 0..2^ADDR_W-1.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles, rd_en to valid rd_data; legal 1..4.
- PACE_MAX, 9999: idle cycles inserted between addresses. 9999 is for simulation; board build uses 9_999_999. 0 means no pacing.
- EXP_XOR, 0: expected data = address[DATA_W-1:0] XOR EXP_XOR.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse, already debounced upstream; begins a sweep.
- abort  in  1  single-cycle pulse; cancels a sweep.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data.
- busy  out  1  high from the first ISSUE through DONE.
- done  out  1  one-cycle pulse at the end of a completed sweep.
- pass  out  1  high after a completed sweep with zero errors; held until next start.
- err_cnt  out  ADDR_W+1  number of mismatching locations, 0..256.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 while err_cnt==0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK, PACE, DONE.
- IDLE:
  - start → ISSUE, with rd_addr=0.
  - On entry from start, clear err_cnt, first_err_addr and pass.
- ISSUE: rd_en=1 for exactly one cycle → WAIT.
- WAIT: hold for RD_LAT-1 cycles using a latency counter → CHECK. With RD_LAT=1, WAIT lasts 0 cycles and the FSM goes ISSUE→CHECK.
- CHECK: sample rd_data and compare against rd_addr ^ EXP_XOR. On mismatch:
  - increment err_cnt;
  - if err_cnt was 0, load first_err_addr=rd_addr.
- After CHECK:
  - rd_addr==2^ADDR_W-1 → DONE; the last address gets no pacing;
  - else PACE_MAX==0 → ISSUE with rd_addr+1;
  - else → PACE.
- PACE: count 0..PACE_MAX-1, then → ISSUE with rd_addr+1.
- DONE: done=1 for one cycle; pass=(err_cnt==0) → IDLE.
- rd_addr does not wrap during a sweep. It is held at 255 after DONE and reloaded to 0 on the next start.
- start while busy is ignored.
- abort in any non-IDLE state → IDLE next cycle:
  - rd_en=0, no done pulse, pass=0;
  - err_cnt and first_err_addr keep their partial values.
- abort and start in the same IDLE cycle: abort wins and the FSM stays IDLE.
- Reset mid-sweep: everything returns to reset values immediately.

## Timing
- Reset values: rd_en=0, rd_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0. FSM=IDLE, pace and latency counters 0.
- start sampled at edge N → ISSUE during cycle N+1 (rd_en high), busy high from N+1.
- Per-address period is RD_LAT+1+PACE_MAX cycles: ISSUE (1) + WAIT (RD_LAT-1) + CHECK (1) + PACE (PACE_MAX).
- Sweep length:
  - start-to-done = 256·(RD_LAT+1) + 255·PACE_MAX + 1 cycles;
  - with RD_LAT=1, PACE_MAX=0: done is asserted in cycle N+514.
- rd_data is sampled only in CHECK; its value at any other time is ignored.
- Outputs are registered, except rd_en and busy, which are decoded from FSM state.

## Structure
- Package ram_pkg holds ADDR_W, DATA_W and the FSM state encoding (localparams). It is shared with the write-side controller and the RAM wrapper.
- One sub-module, ram_rd_pacer: a parameterised down-counter.
  - Inputs: load, en.
  - Output: expire.
  - Used for both the WAIT latency count and the PACE count, instantiated twice.
- The compare and error bookkeeping stay in the top level.

## Test plan
- Clean RAM (mem[i]=i), RD_LAT=1, PACE_MAX=0, start pulse → rd_addr walks 0..255, one rd_en per 2 cycles; done at N+514, pass=1, err_cnt=0, first_err_addr=0.
- Corrupt mem[0x17]=0x00 and mem[0xC0]=0xFF → done, pass=0, err_cnt=2, first_err_addr=0x17.
- RD_LAT=3, PACE_MAX=4, clean RAM → rd_en spacing 8 cycles; done exactly 256·4+255·4+1 cycles after start; pass=1.
- abort at rd_addr=0x40 mid-PACE, with one earlier error at 0x10 → IDLE next cycle, no done, pass=0, err_cnt=1, first_err_addr=0x10. A following start clears the results and completes normally.
- start repeated while busy, and start+abort together in IDLE → no restart or address jump during the sweep; the simultaneous pair leaves busy=0.
- rst_n asserted mid-sweep at rd_addr=0x80 → all outputs return to reset values asynchronously; the next start sweeps from 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the 256x8 test RAM: geometry, read-checker FSM encoding
// and the expected fill pattern used by both the write side and the checker.
package ram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PACE  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Each location holds its own address, optionally scrambled with a constant.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] pattern);
    return DATA_W'(addr) ^ pattern;
  endfunction

endpackage

// File: rtl/ram_rd_pacer.sv
// Loadable down-counter; expire is high once the count has reached zero.
module ram_rd_pacer #(
  parameter int unsigned   W        = 1,
  parameter logic [W-1:0]  LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ram_rd_check.sv
// Read-back checker: sweeps the whole RAM, compensates read latency, paces the
// sweep and reports pass, error count and first failing address.
module ram_rd_check
  import ram_pkg::*;
#(
  parameter int unsigned         RD_LAT   = 1,
  parameter int unsigned         PACE_MAX = 9999,
  parameter logic [DATA_W-1:0]   EXP_XOR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned LAT_W     = $clog2(RD_LAT + 1);
  localparam int unsigned PACE_W    = $clog2(PACE_MAX + 2);
  localparam int unsigned LAT_LOAD  = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam int unsigned PACE_LOAD = (PACE_MAX > 0) ? PACE_MAX - 1 : 0;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic [2:0]        state_q, state_d, fsm_nxt;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              lat_expire, pace_expire;
  logic              sweep_go, step, mismatch, last_addr;

  ram_rd_pacer #(.W(LAT_W), .LOAD_VAL(LAT_W'(LAT_LOAD))) u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == S_ISSUE),
    .en     (state_q == S_WAIT),
    .expire (lat_expire)
  );

  ram_rd_pacer #(.W(PACE_W), .LOAD_VAL(PACE_W'(PACE_LOAD))) u_pace (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == S_CHECK),
    .en     (state_q == S_PACE),
    .expire (pace_expire)
  );

  assign last_addr = (rd_addr_q == ADDR_LAST);
  assign sweep_go  = (state_q == S_IDLE) && start && !abort;
  assign mismatch  = (state_q == S_CHECK) && (rd_data != exp_data(rd_addr_q, EXP_XOR));
  assign step      = !abort && (((state_q == S_CHECK) && !last_addr && (PACE_MAX == 0)) ||
                                ((state_q == S_PACE) && pace_expire));

  always_comb begin
    fsm_nxt = state_q;
    case (state_q)
      S_IDLE:  fsm_nxt = start ? S_ISSUE : S_IDLE;
      S_ISSUE: fsm_nxt = (RD_LAT > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  fsm_nxt = lat_expire ? S_CHECK : S_WAIT;
      S_CHECK: begin
        if (last_addr) begin
          fsm_nxt = S_DONE;
        end else if (PACE_MAX == 0) begin
          fsm_nxt = S_ISSUE;
        end else begin
          fsm_nxt = S_PACE;
        end
      end
      S_PACE:  fsm_nxt = pace_expire ? S_ISSUE : S_PACE;
      S_DONE:  fsm_nxt = S_IDLE;
      default: fsm_nxt = S_IDLE;
    endcase
    // abort beats everything, including a simultaneous start in IDLE
    state_d = abort ? S_IDLE : fsm_nxt;
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    pass_d    = pass_q;
    done_d    = (state_q == S_DONE) && !abort;
    if (sweep_go) begin
      rd_addr_d = '0;
    end else if (step) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end else begin
      rd_addr_d = rd_addr_q;
    end
    if (sweep_go) begin
      err_cnt_d = '0;
      first_d   = '0;
    end else if (mismatch) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
      first_d   = (err_cnt_q == '0) ? rd_addr_q : first_q;
    end else begin
      err_cnt_d = err_cnt_q;
      first_d   = first_q;
    end
    if (sweep_go || (abort && (state_q != S_IDLE))) begin
      pass_d = 1'b0;
    end else if (state_q == S_DONE) begin
      pass_d = (err_cnt_q == '0);
    end else begin
      pass_d = pass_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
    end
  end

  assign rd_en          = (state_q == S_ISSUE);
  assign busy           = (state_q != S_IDLE);
  assign rd_addr        = rd_addr_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;
  assign pass           = pass_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ram_rd_check.sv
// Directed bench: two checkers (latency 1 / no pacing, latency 3 / pacing 4)
// each reading its own behavioural RAM model.
module tb_ram_rd_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, abort_a, rd_en_a, busy_a, done_a, pass_a;
  logic [7:0] rd_addr_a, rd_data_a, first_a;
  logic [8:0] err_cnt_a;
  logic       start_b, abort_b, rd_en_b, busy_b, done_b, pass_b;
  logic [7:0] rd_addr_b, rd_data_b, first_b;
  logic [8:0] err_cnt_b;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_b [3];
  int n_tests = 0;
  int n_fail  = 0;
  int jd, bad, cnt;

  always #5 clk = ~clk;

  ram_rd_check #(.RD_LAT(1), .PACE_MAX(0), .EXP_XOR(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_cnt_a), .first_err_addr(first_a));

  ram_rd_check #(.RD_LAT(3), .PACE_MAX(4), .EXP_XOR(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_cnt_b), .first_err_addr(first_b));

  // RAM models: data appears RD_LAT cycles after the read address is presented
  always @(posedge clk) begin
    rd_data_a <= mem_a[rd_addr_a];
    pipe_b[0] <= mem_b[rd_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_data_b = pipe_b[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep on A: ISSUE every 2 cycles, done 513 edges after the start edge.
  task automatic sweep_a(input int repeat_at, output int j_done, output int n_bad);
    logic       e_en;
    logic [7:0] e_addr;
    n_bad  = 0;
    j_done = -1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int j = 0; j <= 600; j++) begin
      if (j > 0) tick;
      start_a = (j == repeat_at);
      e_en   = (j <= 511) && (j % 2 == 0);
      e_addr = (j <= 511) ? 8'(j / 2) : 8'hFF;
      if (j < 513 && (rd_en_a !== e_en || rd_addr_a !== e_addr || busy_a !== 1'b1)) n_bad++;
      if (done_a === 1'b1) begin
        j_done = j;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  // Sweep on B: period 8 (ISSUE, 2 WAIT, CHECK, 4 PACE), done at 2045.
  task automatic sweep_b(input int abort_at, output int j_done, output int n_bad);
    logic       e_en;
    logic [7:0] e_addr;
    n_bad  = 0;
    j_done = -1;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int j = 0; j <= 2200; j++) begin
      if (j > 0) tick;
      e_en   = (j <= 2040) && (j % 8 == 0);
      e_addr = (j <= 2043) ? 8'(j / 8) : 8'hFF;
      if (j < 2045 && (rd_en_b !== e_en || rd_addr_b !== e_addr || busy_b !== 1'b1)) n_bad++;
      if (j == abort_at || done_b === 1'b1) begin
        j_done = j;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {start_a, abort_a, start_b, abort_b} = 4'b0000;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(i);
    end
    tick;
    tick;
    chk("reset_a", {rd_en_a, rd_addr_a, busy_a, done_a, pass_a, err_cnt_a, first_a}, 32'd0);
    chk("reset_b", {rd_en_b, rd_addr_b, busy_b, done_b, pass_b, err_cnt_b, first_b}, 32'd0);
    #2 rst_n = 1'b1;
    tick;
    chk("idle_busy", {busy_a, busy_b}, 32'd0);

    // clean sweep, latency 1, no pacing
    sweep_a(-1, jd, bad);
    chk("a_clean_seq", bad, 0);
    chk("a_clean_done_cyc", jd, 513);
    chk("a_clean_result", {pass_a, err_cnt_a, first_a, busy_a}, {1'b1, 9'd0, 8'h00, 1'b0});
    chk("a_addr_held", rd_addr_a, 8'hFF);
    tick;
    chk("a_done_one_cycle", {done_a, pass_a}, 2'b01);

    // two corrupted locations, plus a start repeated mid-sweep
    mem_a[8'h17] = 8'h00;
    mem_a[8'hC0] = 8'hFF;
    sweep_a(100, jd, bad);
    chk("a_corrupt_seq", bad, 0);
    chk("a_corrupt_done_cyc", jd, 513);
    chk("a_corrupt_result", {pass_a, err_cnt_a, first_a}, {1'b0, 9'd2, 8'h17});
    mem_a[8'h17] = 8'h17;
    mem_a[8'hC0] = 8'hC0;

    // start and abort together in IDLE: stays idle
    start_a = 1'b1;
    abort_a = 1'b1;
    tick;
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("a_start_abort_idle", {busy_a, rd_en_a}, 2'b00);
    tick;
    chk("a_start_abort_idle2", {busy_a, rd_en_a, err_cnt_a}, {2'b00, 9'd2});

    // latency 3, pacing 4, clean RAM
    sweep_b(-1, jd, bad);
    chk("b_clean_seq", bad, 0);
    chk("b_clean_done_cyc", jd, 2045);
    chk("b_clean_result", {pass_b, err_cnt_b, first_b}, {1'b1, 9'd0, 8'h00});

    // abort mid-PACE at address 0x40 with an earlier error at 0x10
    mem_b[8'h10] = 8'h55;
    sweep_b(517, jd, bad);
    chk("b_abort_seq", bad, 0);
    chk("b_abort_point", {rd_addr_b, rd_en_b, busy_b}, {8'h40, 1'b0, 1'b1});
    abort_b = 1'b1;
    tick;
    abort_b = 1'b0;
    chk("b_abort_idle", {busy_b, rd_en_b, done_b, pass_b}, 4'b0000);
    chk("b_abort_partial", {err_cnt_b, first_b}, {9'd1, 8'h10});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_b === 1'b1 || busy_b !== 1'b0) cnt++;
    end
    chk("b_abort_no_done", cnt, 0);
    mem_b[8'h10] = 8'h10;
    sweep_b(-1, jd, bad);
    chk("b_rerun_seq", bad, 0);
    chk("b_rerun_done_cyc", jd, 2045);
    chk("b_rerun_result", {pass_b, err_cnt_b, first_b}, {1'b1, 9'd0, 8'h00});

    // asynchronous reset mid-sweep at address 0x80
    mem_a[8'h05] = 8'h00;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    cnt = 0;
    while (rd_addr_a !== 8'h80 && cnt < 400) begin
      tick;
      cnt++;
    end
    chk("a_reach_0x80", {rd_addr_a, err_cnt_a}, {8'h80, 9'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_reset", {rd_en_a, rd_addr_a, busy_a, done_a, pass_a, err_cnt_a, first_a}, 32'd0);
    #2 rst_n = 1'b1;
    mem_a[8'h05] = 8'h05;
    tick;
    chk("a_post_reset_idle", {busy_a, rd_en_a}, 2'b00);
    sweep_a(-1, jd, bad);
    chk("a_post_reset_seq", bad, 0);
    chk("a_post_reset_done_cyc", jd, 513);
    chk("a_post_reset_result", {pass_a, err_cnt_a, first_a}, {1'b1, 9'd0, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
